// File: rtl/audio_pkg.sv
// Shared types and default widths for the audio record/playback stage.
package audio_pkg;
  localparam int AUDIO_DATA_WIDTH = 16;
  localparam int AUDIO_ADDR_WIDTH = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_PLAY   = 2'd2
  } state_t;
endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample memory: one write port, one registered read port.
module sample_ram
  import audio_pkg::*;
#(
  parameter int ADDR_WIDTH = AUDIO_ADDR_WIDTH,
  parameter int DATA_WIDTH = AUDIO_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Array has no reset so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/audio_sample_recorder.sv
// Record/playback stage: captures ADC words into sample memory and replays
// them to the DAC on request, once or looped, with optional live monitoring.
module audio_sample_recorder
  import audio_pkg::*;
#(
  parameter int ADDR_WIDTH = AUDIO_ADDR_WIDTH,
  parameter int DATA_WIDTH = AUDIO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_end,
  input  logic [DATA_WIDTH-1:0] audio_input,
  input  logic                  sample_req,
  output logic [DATA_WIDTH-1:0] audio_output,
  input  logic                  rec_start,
  input  logic                  play_start,
  input  logic                  stop,
  input  logic                  loop,
  input  logic                  monitor,
  output logic                  recording,
  output logic                  playing,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   level
);
  localparam int LVL_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]      r_level;
  logic                  r_full, r_recording, r_playing;
  logic [DATA_WIDTH-1:0] r_audio_output, r_mon;

  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [LVL_W-1:0]      w_level_nxt;
  logic                  w_full_nxt, w_we, w_at_last;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_at_last = ({1'b0, r_rd_ptr} == (r_level - LVL_W'(1)));

  // Command decode and pointer/level next-state; stop > rec_start > play_start.
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_level_nxt  = r_level;
    w_full_nxt   = r_full;
    w_we         = 1'b0;
    if (stop) begin
      w_state_nxt = ST_IDLE;
    end else if (rec_start) begin
      w_state_nxt  = ST_RECORD;
      w_wr_ptr_nxt = {ADDR_WIDTH{1'b0}};
      w_level_nxt  = {LVL_W{1'b0}};
      w_full_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_RECORD: begin
          if (sample_end) begin
            w_we         = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + ADDR_WIDTH'(1);
            w_level_nxt  = {1'b0, r_wr_ptr} + LVL_W'(1);
            if (r_wr_ptr == LAST_ADDR) begin
              w_full_nxt  = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_state_nxt = ST_RECORD;
            end
          end else begin
            w_we = 1'b0;
          end
        end
        ST_IDLE, ST_PLAY: begin
          if (play_start) begin
            if (r_level == {LVL_W{1'b0}}) begin
              w_state_nxt = ST_IDLE;
            end else begin
              w_state_nxt  = ST_PLAY;
              w_rd_ptr_nxt = {ADDR_WIDTH{1'b0}};
            end
          end else if ((r_state == ST_PLAY) && sample_req) begin
            if (!w_at_last) begin
              w_rd_ptr_nxt = r_rd_ptr + ADDR_WIDTH'(1);
            end else if (loop) begin
              w_rd_ptr_nxt = {ADDR_WIDTH{1'b0}};
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_state_nxt = r_state;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, pointers and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= {ADDR_WIDTH{1'b0}};
      r_rd_ptr    <= {ADDR_WIDTH{1'b0}};
      r_level     <= {LVL_W{1'b0}};
      r_full      <= 1'b0;
      r_recording <= 1'b0;
      r_playing   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_level     <= w_level_nxt;
      r_full      <= w_full_nxt;
      r_recording <= (w_state_nxt == ST_RECORD);
      r_playing   <= (w_state_nxt == ST_PLAY);
    end
  end

  // RAM is addressed with the next read pointer so rdata tracks r_rd_ptr.
  sample_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_we & ~reset),
    .i_waddr (r_wr_ptr),
    .i_wdata (audio_input),
    .i_raddr (w_rd_ptr_nxt),
    .o_rdata (w_rdata)
  );

  // Output register: RAM data while playing, otherwise monitored input or silence.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_audio_output <= {DATA_WIDTH{1'b0}};
      r_mon          <= {DATA_WIDTH{1'b0}};
    end else begin
      if (sample_end) begin
        r_mon <= audio_input;
      end
      if (r_state == ST_PLAY) begin
        r_audio_output <= w_rdata;
      end else if (monitor) begin
        r_audio_output <= sample_end ? audio_input : r_mon;
      end else begin
        r_audio_output <= {DATA_WIDTH{1'b0}};
      end
    end
  end

  assign audio_output = r_audio_output;
  assign recording    = r_recording;
  assign playing      = r_playing;
  assign full         = r_full;
  assign level        = r_level;
endmodule

// File: doc/audio_sample_recorder.md
Name: audio_sample_recorder

Overview:
- Record/playback stage between the serial-to-parallel codec interface and the DAC data path, on the audio clock domain.
- Captures `audio_input` words on `sample_end` pulses into an on-chip sample memory.
- Replays the recorded words on `audio_output` as the codec raises `sample_req`, once or looped.
- When not playing, it optionally monitors the live input straight through to `audio_output`.

Parameters:
- ADDR_WIDTH, 15: sample memory address width. Capacity DEPTH = 2**ADDR_WIDTH words, about 0.74 s at 44.1 kHz.
- DATA_WIDTH, 16: sample word width. Matches the codec word.

Ports:
- clk  in  1  audio clock (11.2896 MHz). All logic is on this edge.
- reset  in  1  synchronous, active-high.
- sample_end  in  1  one-cycle pulse: `audio_input` holds a new valid ADC word.
- audio_input  in  DATA_WIDTH  ADC sample word.
- sample_req  in  1  one-cycle pulse: the codec requests the next DAC word.
- audio_output  out  DATA_WIDTH  DAC sample word. Registered.
- rec_start  in  1  one-cycle pulse (debounced upstream): begin a new recording.
- play_start  in  1  one-cycle pulse: begin playback from sample 0.
- stop  in  1  one-cycle pulse: abort record or play.
- loop  in  1  level: 1 = restart at sample 0 after the last sample.
- monitor  in  1  level: 1 = pass `audio_input` to `audio_output` while not playing.
- recording  out  1  state is RECORD.
- playing  out  1  state is PLAY.
- full  out  1  the last recording stopped because memory was exhausted.
- level  out  ADDR_WIDTH+1  number of valid recorded samples, 0..DEPTH.

Behaviour:
- **Reset** (sync, reset=1 at a clk edge):
  - State IDLE; `wr_ptr`, `rd_ptr`, `level` = 0; `audio_output` = 0.
  - `full`, `recording`, `playing` = 0.
  - Memory contents are not cleared. Reset asserted mid-record or mid-play aborts immediately with the same values.
- **States**: IDLE, RECORD, PLAY. `recording` and `playing` are registered decodes of the state.
- **Command priority per cycle**: stop > rec_start > play_start. All three pulses are ignored while reset=1.
- **stop**: any state → IDLE. `level` is kept, so a partial recording stays playable.
- **rec_start** (any state, including PLAY):
  - Sets `wr_ptr`=0, `level`=0, `full`=0, enters RECORD on the next cycle.
  - A `sample_end` in that same cycle is not stored.
- **RECORD**, on `sample_end`:
  - mem[`wr_ptr`] <= `audio_input`; `wr_ptr`++; `level` <= `wr_ptr`+1.
  - When the write lands at address DEPTH-1: `level`=DEPTH, `full`=1, → IDLE.
  - Never wraps and never overwrites.
- **play_start** from IDLE or PLAY:
  - If `level`=0, ignore it and stay/return to IDLE.
  - Else `rd_ptr`=0 and enter PLAY, prefetching sample 0: `audio_output` = mem[0] exactly 2 cycles after the play_start cycle (1 RAM read + 1 output register).
- **play_start** in RECORD: ignored.
- **PLAY**, on `sample_req` at `rd_ptr`=p:
  - If p < `level`-1: `rd_ptr`=p+1, and `audio_output` = mem[p+1] 2 cycles after `sample_req`.
  - If p = `level`-1 and `loop`=1: `rd_ptr`=0, and `audio_output` = mem[0] 2 cycles later.
  - If p = `level`-1 and `loop`=0: → IDLE, and `audio_output` takes the IDLE rule 2 cycles later.
  - The word held on `audio_output` when `sample_req` arrives is the one the codec consumes. Sample k is therefore consumed on the k-th request after prefetch.
- **IDLE/RECORD output**: `audio_output` = `monitor` ? (`audio_input` registered on each `sample_end`) : 0. When `monitor` falls, the output is 0 on the next cycle.
- **Simultaneous events**:
  - `sample_end` and `sample_req` in the same cycle are independent; the write and read ports are separate.
  - `stop` together with a last-sample event: `stop` wins and `full` is not set.
- `loop` and `monitor` are sampled every cycle; changing them mid-play takes effect at the next boundary.
- **Widths**:
  - Pointers are ADDR_WIDTH bits.
  - `level` is ADDR_WIDTH+1 bits, so DEPTH is representable.
  - No arithmetic on sample data.

Decomposition:
- Package `audio_pkg`:
  - state enum (IDLE/RECORD/PLAY);
  - AUDIO_DATA_WIDTH=16;
  - default ADDR_WIDTH.
- Sub-module `sample_ram`:
  - simple dual-port synchronous RAM, DEPTH x DATA_WIDTH;
  - write port (we, waddr, wdata) and read port (raddr, registered rdata, 1-cycle latency);
  - infers block RAM, no reset on the array.

Test Plan:
- **Reset**: reset=1 for 3 cycles during PLAY → next cycle `audio_output`=0, `playing`=0, `level`=0, `full`=0.
- **Record and play**:
  - Stimulus: rec_start, then 5 `sample_end` with inputs 0x0001..0x0005, then stop, then play_start with `loop`=0, then 5 `sample_req`.
  - Response: `level`=5; `audio_output` = 0x0001 two cycles after play_start; each request advances to the next value; after the 5th request, IDLE and output 0 (`monitor`=0).
- **Loop**: same 5 samples with `loop`=1, 12 `sample_req` → consumed sequence 1,2,3,4,5,1,2,3,4,5,1,2 and `playing` stays 1.
- **Full**:
  - Stimulus: ADDR_WIDTH=4, record 20 `sample_end` words.
  - Response: only the first 16 are stored; `level`=16; `full`=1; IDLE after the 16th write; the 17th–20th are ignored.
- **Priority**:
  - stop+rec_start in the same cycle during RECORD → IDLE, `level` retained.
  - rec_start during PLAY → RECORD, `level`=0, `full`=0.
- **Monitor / empty**:
  - IDLE, `monitor`=1, `sample_end` with 0xBEEF → `audio_output`=0xBEEF next cycle.
  - play_start with `level`=0 → remains IDLE.
